// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one downstream APB master port between NUM_MASTERS
// upstream requesters. One transfer per grant, with a per-transfer ACCESS timeout
// that completes the transfer towards the requester with an error.
module apb_master_arbiter #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned APB_DATA_WIDTH = 8,
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                   apb_pclk_i,
    input  logic                                   apb_preset_ni,
    input  logic [NUM_MASTERS-1:0]                 mst_psel_i,
    input  logic [NUM_MASTERS-1:0]                 mst_penable_i,
    input  logic [NUM_MASTERS-1:0]                 mst_pwrite_i,
    input  logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0]  mst_paddr_i,
    input  logic [NUM_MASTERS*APB_DATA_WIDTH-1:0]  mst_pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]              mst_prdata_o,
    output logic [NUM_MASTERS-1:0]                 mst_pready_o,
    output logic [NUM_MASTERS-1:0]                 mst_pslverr_o,
    output logic                                   apb_psel_o,
    output logic                                   apb_penable_o,
    output logic                                   apb_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]              apb_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]              apb_pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]              apb_prdata_i,
    input  logic                                   apb_pready_i,
    input  logic                                   apb_pslverr_i
);

    localparam int unsigned AW     = APB_ADDR_WIDTH;
    localparam int unsigned DW     = APB_DATA_WIDTH;
    localparam int unsigned N      = NUM_MASTERS;
    localparam int unsigned GW     = $clog2(N);
    localparam int unsigned CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The abort is signalled in the last allowed ACCESS cycle.
    localparam int unsigned ToLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   rr_q;
    logic            psel_q;
    logic            penable_q;
    logic            pwrite_q;
    logic [AW-1:0]   paddr_q;
    logic [DW-1:0]   pwdata_q;
    logic [CW-1:0]   cnt_q;

    logic [AW-1:0]   addr_arr  [N];
    logic [DW-1:0]   wdata_arr [N];
    logic            pick_valid;
    logic [GW-1:0]   pick_idx;
    logic [GW-1:0]   cand;
    logic [GW-1:0]   rr_next;
    logic            timeout_hit;
    logic            xfer_done;
    logic            timed_out;

    // Arbitration ignores penable; it is only part of the upstream protocol.
    logic unused_penable;
    assign unused_penable = ^mst_penable_i;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign addr_arr[g]  = mst_paddr_i[g*AW +: AW];
        assign wdata_arr[g] = mst_pwdata_i[g*DW +: DW];
    end

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned o = 0; o < N; o++) begin
            cand = GW'((32'(rr_q) + o) % N);
            if (!pick_valid && mst_psel_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(ToLast));
    assign xfer_done   = (state_q == StAccess) && (apb_pready_i || timeout_hit);
    // pready wins over a timeout landing in the same cycle.
    assign timed_out   = (state_q == StAccess) && !apb_pready_i && timeout_hit;
    assign rr_next     = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;

    // Upstream response is steered combinationally to the granted requester.
    always_comb begin
        mst_pready_o  = '0;
        mst_pslverr_o = '0;
        mst_prdata_o  = '0;
        if (xfer_done) begin
            mst_pready_o[grant_q]  = 1'b1;
            mst_pslverr_o[grant_q] = apb_pslverr_i | timed_out;
            mst_prdata_o           = timed_out ? '0 : apb_prdata_i;
        end
    end

    // Transfer sequencer with registered downstream outputs.
    always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
        if (!apb_preset_ni) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            rr_q      <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_q  <= pick_idx;
                        pwrite_q <= mst_pwrite_i[pick_idx];
                        paddr_q  <= addr_arr[pick_idx];
                        pwdata_q <= wdata_arr[pick_idx];
                        psel_q   <= 1'b1;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (xfer_done) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rr_q      <= rr_next;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign apb_psel_o    = psel_q;
    assign apb_penable_o = penable_q;
    assign apb_pwrite_o  = pwrite_q;
    assign apb_paddr_o   = paddr_q;
    assign apb_pwdata_o  = pwdata_q;

endmodule
